cpu_fetch_stage: RTL and testbench

//  Parametrised instruction-fetch stage (step 1) with decoupling fetch buffer.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/instractions.sv | 18 +
 rtl/cpu_fetch_stage.sv | 107 ++++++++++
 tb/tb_cpu_fetch_stage.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared front-end definitions: fetch FSM states, redirect select encoding and
// the NOP word substituted for instructions fetched from outside the ROM.
package cpu_pkg;

  localparam int unsigned NOP_WORD = 0;

  localparam logic REDIR_BRANCH = 1'b0;
  localparam logic REDIR_JUMP   = 1'b1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: circular FIFO with wrap-around pointers, flush, occupancy count
// and a head output taken straight from the storage registers.
module fetch_fifo import cpu_pkg::*; #(
  parameter int W     = 65,
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [W-1:0]                 wdata_i,
  output logic [W-1:0]                 rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Pointer and occupancy next-state; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      else        rd_ptr_d = rd_ptr_q;
      if (push_i && !pop_i)      count_d = count_q + CW'(1);
      else if (pop_i && !push_i) count_d = count_q - CW'(1);
      else                       count_d = count_q;
    end
  end

  // Pointer, count and storage registers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == {CW{1'b0}});
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/instractions.sv
// Instruction ROM with combinational read; word i holds 17*i+90 (mod 2^WIDTH),
// addresses at or beyond DEPTH read as zero.
module instractions import cpu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic [WIDTH-1:0] addr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic             in_range_s;
  logic [63:0]      word_s;

  assign in_range_s = (64'(addr_i) < 64'(DEPTH));
  assign word_s     = 64'(addr_i) * 64'd17 + 64'd90;
  assign rdata_o    = in_range_s ? word_s[WIDTH-1:0] : {WIDTH{1'b0}};

endmodule

// File: rtl/cpu_fetch_stage.sv
// Instruction-fetch stage: PC and redirect control, ROM read, and a decoupling
// buffer handing {pc+1, instr, fault} to decode over valid/ready.
module cpu_fetch_stage import cpu_pkg::*; #(
  parameter int               WIDTH         = 32,
  parameter int               INSTR_NUMBERS = 16,
  parameter int               FIFO_DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                fetch_en,
  input  logic                                redirect_valid,
  input  logic                                redirect_sel,
  input  logic [WIDTH-1:0]                    pc_plus_one_plus_IMM_step_4,
  input  logic [WIDTH-1:0]                    ext_ADDR_step_4,
  input  logic                                out_ready,
  output logic                                out_valid,
  output logic [WIDTH-1:0]                    pc_plus_one_step_1,
  output logic [WIDTH-1:0]                    instr_step_1,
  output logic                                fault_step_1,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     buf_count,
  output logic                                halted
);

  localparam int EW = 2 * WIDTH + 1;

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] mem_rdata_s, instr_s;
  logic             fault_s, pop_s, push_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [EW-1:0]    entry_s, head_s;

  instractions #(
    .WIDTH (WIDTH),
    .DEPTH (INSTR_NUMBERS)
  ) u_imem (
    .addr_i  (pc_q),
    .rdata_o (mem_rdata_s)
  );

  assign fault_s = (64'(pc_q) >= 64'(INSTR_NUMBERS));
  assign instr_s = fault_s ? WIDTH'(NOP_WORD) : mem_rdata_s;
  assign entry_s = {pc_q + WIDTH'(1), instr_s, fault_s};

  // A pop in the redirect cycle still completes; only the push is suppressed.
  assign pop_s  = !fifo_empty_s && out_ready;
  assign push_s = (state_q == RUN) && fetch_en && !redirect_valid && (!fifo_full_s || pop_s);

  fetch_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (redirect_valid),
    .wdata_i (entry_s),
    .rdata_o (head_s),
    .count_o (buf_count),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s)
  );

  // Next PC and fetch state; redirect overrides everything, including HALT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      state_d = RUN;
      pc_d    = (redirect_sel == REDIR_JUMP) ? ext_ADDR_step_4 : pc_plus_one_plus_IMM_step_4;
    end else begin
      case (state_q)
        RUN: begin
          if (push_s) begin
            pc_d    = pc_q + WIDTH'(1);
            state_d = fault_s ? HALT : RUN;
          end else begin
            pc_d    = pc_q;
            state_d = RUN;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  // PC and fetch-state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid          = !fifo_empty_s;
  assign pc_plus_one_step_1 = head_s[EW-1 -: WIDTH];
  assign instr_step_1       = head_s[WIDTH:1];
  assign fault_step_1       = head_s[0];
  assign halted             = (state_q == HALT);

endmodule

// File: tb/tb_cpu_fetch_stage.sv
// Directed bench for cpu_fetch_stage: a behavioural model fills a scoreboard of
// expected buffer entries, compared against the DUT head every cycle.
module tb_cpu_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en, redirect_valid, redirect_sel, out_ready;
  logic [31:0] br_tgt, jmp_tgt;
  logic        out_valid, fault;
  logic [31:0] pc1, instr;
  logic [1:0]  buf_count;
  logic        halted;

  logic [7:0]  br8, jmp8, pc18, instr8;
  logic        ov8, fault8, halted8;
  logic [1:0]  bc8;

  typedef struct packed {
    logic [31:0] pc1;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] pc_m;
  logic        halted_m;
  int          n_asserts = 0;
  int          n_fail    = 0;

  always #5 clk = ~clk;

  cpu_fetch_stage dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_sel(redirect_sel), .pc_plus_one_plus_IMM_step_4(br_tgt),
    .ext_ADDR_step_4(jmp_tgt), .out_ready(out_ready), .out_valid(out_valid),
    .pc_plus_one_step_1(pc1), .instr_step_1(instr), .fault_step_1(fault),
    .buf_count(buf_count), .halted(halted)
  );

  cpu_fetch_stage #(.WIDTH(8), .INSTR_NUMBERS(256)) dut8 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_sel(redirect_sel), .pc_plus_one_plus_IMM_step_4(br8),
    .ext_ADDR_step_4(jmp8), .out_ready(out_ready), .out_valid(ov8),
    .pc_plus_one_step_1(pc18), .instr_step_1(instr8), .fault_step_1(fault8),
    .buf_count(bc8), .halted(halted8)
  );

  function automatic logic [31:0] mem32(input logic [31:0] a);
    return a * 32'd17 + 32'd90;
  endfunction

  function automatic logic [7:0] mem8(input logic [7:0] a);
    return a * 8'd17 + 8'd90;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare DUT against the model, advance the model by one edge, then clock.
  task automatic cycle();
    ent_t e;
    logic pop_m, push_m;
    #1;
    chk("sb_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("sb_count", 64'(buf_count), 64'(sb.size()));
    chk("sb_halted", 64'(halted), 64'(halted_m));
    if (sb.size() != 0) begin
      chk("sb_pc1", 64'(pc1), 64'(sb[0].pc1));
      chk("sb_instr", 64'(instr), 64'(sb[0].instr));
      chk("sb_fault", 64'(fault), 64'(sb[0].fault));
    end
    pop_m  = (sb.size() != 0) && out_ready;
    push_m = !halted_m && fetch_en && !redirect_valid && ((sb.size() < 2) || pop_m);
    if (pop_m) void'(sb.pop_front());
    if (redirect_valid) begin
      sb.delete();
      pc_m     = redirect_sel ? jmp_tgt : br_tgt;
      halted_m = 1'b0;
    end else if (push_m) begin
      e.fault = (pc_m >= 32'd16);
      e.pc1   = pc_m + 32'd1;
      e.instr = e.fault ? 32'd0 : mem32(pc_m);
      sb.push_back(e);
      pc_m = pc_m + 32'd1;
      if (e.fault) halted_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_sel = 1'b0;
    out_ready = 1'b0; br_tgt = 32'd0; jmp_tgt = 32'd0; br8 = 8'd0; jmp8 = 8'd0;
    pc_m = 32'd0; halted_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(buf_count), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_pc1", 64'(pc1), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst8_pc1", 64'(pc18), 64'd0);

    // Streaming from reset.
    rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    cycle();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_pc1", 64'(pc1), 64'd1);
    chk("first_instr", 64'(instr), 64'd90);
    repeat (3) cycle();
    chk("stream_pc1", 64'(pc1), 64'd4);
    chk("stream_instr", 64'(instr), 64'd141);

    // Back-pressure.
    out_ready = 1'b0;
    repeat (5) cycle();
    chk("bp_count", 64'(buf_count), 64'd2);
    chk("bp_hold_pc1", 64'(pc1), 64'd4);
    out_ready = 1'b1;
    cycle();
    chk("bp_rel_pc1", 64'(pc1), 64'd5);
    cycle();
    chk("bp_rel2_pc1", 64'(pc1), 64'd6);

    // Jump redirect with a full buffer.
    out_ready = 1'b0;
    repeat (2) cycle();
    chk("full_count", 64'(buf_count), 64'd2);
    redirect_valid = 1'b1; redirect_sel = 1'b1; jmp_tgt = 32'd7;
    cycle();
    redirect_valid = 1'b0;
    chk("jmp_count", 64'(buf_count), 64'd0);
    chk("jmp_valid", 64'(out_valid), 64'd0);
    cycle();
    chk("jmp_pc1", 64'(pc1), 64'd8);
    chk("jmp_instr", 64'(instr), 64'(mem32(32'd7)));

    // Branch redirect.
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_sel = 1'b0; br_tgt = 32'd3;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("br_pc1", 64'(pc1), 64'd4);
    chk("br_instr", 64'(instr), 64'd141);

    // Run off the end of the ROM into HALT.
    for (int i = 0; i < 30 && !halted; i++) cycle();
    chk("halt_reached", 64'(halted), 64'd1);
    chk("halt_pc1", 64'(pc1), 64'd17);
    chk("halt_fault", 64'(fault), 64'd1);
    chk("halt_instr", 64'(instr), 64'd0);
    repeat (2) cycle();
    chk("halt_nopush", 64'(buf_count), 64'd0);
    chk("halt_stays", 64'(halted), 64'd1);
    redirect_valid = 1'b1; redirect_sel = 1'b1; jmp_tgt = 32'd0;
    cycle();
    redirect_valid = 1'b0;
    chk("unhalt", 64'(halted), 64'd0);
    cycle();
    chk("resume_pc1", 64'(pc1), 64'd1);
    chk("resume_instr", 64'(instr), 64'd90);

    // Asynchronous reset with two buffered entries.
    out_ready = 1'b0;
    cycle();
    chk("pre_rst_count", 64'(buf_count), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(buf_count), 64'd0);
    chk("arst_pc1", 64'(pc1), 64'd0);
    chk("arst_instr", 64'(instr), 64'd0);
    sb.delete(); pc_m = 32'd0; halted_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1; out_ready = 1'b1;
    cycle();
    chk("restart_pc1", 64'(pc1), 64'd1);
    chk("restart_instr", 64'(instr), 64'd90);

    // 8-bit PC wrap-around on the narrow instance.
    redirect_valid = 1'b1; redirect_sel = 1'b1; jmp_tgt = 32'd0; jmp8 = 8'd253;
    cycle();
    redirect_valid = 1'b0;
    chk("w8_valid", 64'(ov8), 64'd0);
    cycle();
    chk("w8_pc1_254", 64'(pc18), 64'd254);
    chk("w8_instr_253", 64'(instr8), 64'(mem8(8'd253)));
    cycle();
    chk("w8_pc1_255", 64'(pc18), 64'd255);
    chk("w8_instr_254", 64'(instr8), 64'(mem8(8'd254)));
    cycle();
    chk("w8_pc1_0", 64'(pc18), 64'd0);
    chk("w8_instr_255", 64'(instr8), 64'(mem8(8'd255)));
    cycle();
    chk("w8_pc1_1", 64'(pc18), 64'd1);
    chk("w8_instr_0", 64'(instr8), 64'(mem8(8'd0)));
    chk("w8_fault", 64'(fault8), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
